// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg -- shared definitions for the 5-stage pipeline control logic.
//   FWD_RF / FWD_WB / FWD_MEM : operand-mux select encodings for EX forwarding
//   md_state_t                : multiply/divide sequencer state
//   MULT_CYCLES_DEF / DIV_CYCLES_DEF : default EX occupancy of mult / div
//   fwd_sel()                 : EX forwarding select for one source register
// ---------------------------------------------------------------------------
package pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam int MULT_CYCLES_DEF = 4;
   localparam int DIV_CYCLES_DEF  = 16;

   typedef enum logic {
      IDLE    = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   // MEM wins over WB because it holds the younger result; $0 never forwards.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic       we_m,
      input logic [4:0] wr_m,
      input logic       we_w,
      input logic [4:0] wr_w
   );
      if (src != 5'd0 && we_m && wr_m == src)
         return FWD_MEM;
      else if (src != 5'd0 && we_w && wr_w == src)
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/md_seq.sv
// ---------------------------------------------------------------------------
// md_seq -- sequencer for the multi-cycle multiply/divide unit in EX.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : EX holds a mult/div in its first cycle (ignored while busy)
//   is_div     : 1 = divide, 0 = multiply (valid with start)
//   busy       : op occupies EX (asserted already in the start cycle)
//   done       : one-cycle pulse in the last busy cycle
// ---------------------------------------------------------------------------
module md_seq
   import pipe_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic is_div,
   output logic busy,
   output logic done
);

   // The start cycle is spent in IDLE and the final cycle sees cnt==0,
   // so N cycles of occupancy load N-2.
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);

   md_state_t        state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             busy_raw, done_raw;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      busy_raw   = 1'b0;
      done_raw   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               cnt_next   = is_div ? DIV_LOAD : MULT_LOAD;
               state_next = MD_BUSY;
               busy_raw   = 1'b1;
            end
         end
         MD_BUSY: begin
            busy_raw = 1'b1;
            if (cnt_reg == '0) begin
               done_raw   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are held low for the whole reset cycle, which also suppresses
   // the done pulse of an aborted operation.
   assign busy = busy_raw & rst_n;
   assign done = done_raw & rst_n;

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- hazard detection, forwarding and mult/div sequencing for the
// 5-stage pipeline.
//   Inputs : RsD/RtD, RsE/RtE source regs; writeReg*/regWrite* per stage;
//            memToRegE/M loads; branchD/branchTakenD; mdStartE/mdDivE.
//   Outputs: stallF/D/E, flushD/E, forwardAE/BE (EX mux), forwardAD/BD
//            (branch compare mux), mdBusy/mdDone.
//   Optional build macro HAZARD_PERF_CNT_EN adds stallCycles / flushCount
//   saturating 32-bit performance counters.
// All outputs are combinational and forced low while rst_n is low.
// ---------------------------------------------------------------------------
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] writeRegE,
   input  logic [4:0] writeRegM,
   input  logic [4:0] writeRegW,
   input  logic       regWriteE,
   input  logic       regWriteM,
   input  logic       regWriteW,
   input  logic       memToRegE,
   input  logic       memToRegM,
   input  logic       branchD,
   input  logic       branchTakenD,
   input  logic       mdStartE,
   input  logic       mdDivE,
   output logic       stallF,
   output logic       stallD,
   output logic       stallE,
   output logic       flushD,
   output logic       flushE,
   output logic [1:0] forwardAE,
   output logic [1:0] forwardBE,
   output logic       forwardAD,
   output logic       forwardBD,
   output logic       mdBusy,
   output logic       mdDone
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stallCycles,
   output logic [31:0] flushCount
`endif
);

   logic       md_busy, md_done;
   logic [4:0] src_d [2];
   logic [4:0] src_e [2];
   logic [1:0] fwd_e [2];
   logic [1:0] fwd_d, lw_hit, br_e_hit, br_m_hit;
   logic       lwstall, brstall, stall_front, flush_e, flush_d;

   assign src_d[0] = RsD;
   assign src_d[1] = RtD;
   assign src_e[0] = RsE;
   assign src_e[1] = RtE;

   // Index 0 serves operand A (Rs), index 1 operand B (Rt).
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_operand
         assign fwd_e[gi]    = fwd_sel(src_e[gi], regWriteM, writeRegM, regWriteW, writeRegW);
         assign fwd_d[gi]    = (src_d[gi] != 5'd0) && regWriteM && (writeRegM == src_d[gi]);
         assign lw_hit[gi]   = (src_d[gi] != 5'd0) && (RtE == src_d[gi]);
         assign br_e_hit[gi] = (src_d[gi] != 5'd0) && regWriteE && (writeRegE == src_d[gi]);
         assign br_m_hit[gi] = (src_d[gi] != 5'd0) && memToRegM && (writeRegM == src_d[gi]);
      end
   endgenerate

   assign lwstall     = memToRegE & (|lw_hit);
   assign brstall     = branchD & ((|br_e_hit) | (|br_m_hit));
   assign stall_front = md_busy | lwstall | brstall;
   // A held EX stage keeps its instruction, so no bubble goes in behind it.
   assign flush_e     = (lwstall | brstall) & ~md_busy;
   // A stalled taken branch re-resolves next cycle, so it is not flushed yet.
   assign flush_d     = branchTakenD & ~stall_front;

   md_seq #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md_seq (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (mdStartE),
      .is_div (mdDivE),
      .busy   (md_busy),
      .done   (md_done)
   );

   assign stallF    = stall_front & rst_n;
   assign stallD    = stall_front & rst_n;
   assign stallE    = md_busy;
   assign flushD    = flush_d & rst_n;
   assign flushE    = flush_e & rst_n;
   assign forwardAE = fwd_e[0] & {2{rst_n}};
   assign forwardBE = fwd_e[1] & {2{rst_n}};
   assign forwardAD = fwd_d[0] & rst_n;
   assign forwardBD = fwd_d[1] & rst_n;
   assign mdBusy    = md_busy;
   assign mdDone    = md_done;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles_reg, flush_count_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles_reg <= '0;
         flush_count_reg  <= '0;
      end else begin
         if (stall_front && stall_cycles_reg != 32'hFFFF_FFFF)
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
         if ((flush_d || flush_e) && flush_count_reg != 32'hFFFF_FFFF)
            flush_count_reg <= flush_count_reg + 32'd1;
      end
   end

   assign stallCycles = stall_cycles_reg & {32{rst_n}};
   assign flushCount  = flush_count_reg & {32{rst_n}};
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Drives stall/flush into the IF/ID and ID/EX pipeline registers.
- Drives forwarding selects into the EX-stage and ID-stage (branch compare) operand muxes.
- Sequences a multi-cycle multiply/divide unit in EX by holding the front of the pipeline until the operation completes.

Parameters:
- MULT_CYCLES, 4, total EX occupancy of a multiply, in cycles (at least 2).
- DIV_CYCLES, 16, total EX occupancy of a divide, in cycles (at least 2).
- CNT_W, 5, width of the busy counter; must hold DIV_CYCLES-1.

Ports:
- clk in 1 — system clock; all state updates on posedge.
- rst_n in 1 — synchronous, active-low reset.
- RsD, RtD in 5 each — source registers of the instruction in ID.
- RsE, RtE in 5 each — source registers of the instruction in EX.
- writeRegE, writeRegM, writeRegW in 5 each — destination register per stage.
- regWriteE, regWriteM, regWriteW in 1 each — register-write enable per stage.
- memToRegE, memToRegM in 1 each — load in EX / MEM.
- branchD in 1 — ID holds a branch.
- branchTakenD in 1 — branch resolved taken in ID.
- mdStartE in 1 — EX holds a mult/div, first cycle.
- mdDivE in 1 — 1 = divide, 0 = multiply (valid with mdStartE).
- stallF, stallD, stallE out 1 each — hold the PC, IF/ID and ID/EX registers.
- flushD, flushE out 1 each — clear IF/ID, clear ID/EX (insert bubble).
- forwardAE, forwardBE out 2 each — 00 register file, 10 from MEM, 01 from WB.
- forwardAD, forwardBD out 1 each — branch operand taken from MEM.
- mdBusy out 1 — multi-cycle op in progress.
- mdDone out 1 — one-cycle pulse on the last busy cycle.

Behaviour:
- State: FSM {IDLE, MD_BUSY} plus down-counter cnt[CNT_W-1:0].
- Reset: on posedge with rst_n=0, state=IDLE and cnt=0. While rst_n=0, every output is forced to 0. Reset mid-MD_BUSY aborts the operation with no mdDone pulse.
- Register $0 never creates a dependency: every compare requires the register field to be nonzero.
- forwardAE:
  - 10 if regWriteM and writeRegM==RsE.
  - else 01 if regWriteW and writeRegW==RsE.
  - else 00.
  - MEM has priority over WB.
- forwardBE: same rules with RtE.
- forwardAD/forwardBD: regWriteM and writeRegM == RsD/RtD respectively.
- lwstall = memToRegE and (RtE==RsD or RtE==RtD).
- brstall = branchD and (regWriteE and writeRegE ∈ {RsD,RtD}, or memToRegM and writeRegM ∈ {RsD,RtD}).
- IDLE, mdStartE=1:
  - load cnt = (mdDivE ? DIV_CYCLES : MULT_CYCLES) - 2.
  - go to MD_BUSY.
  - mdBusy and stall outputs assert combinationally in this same cycle, so EX occupancy totals the full N cycles.
- MD_BUSY: cnt decrements each cycle. When cnt==0, mdDone=1 and the FSM returns to IDLE next edge. mdStartE is ignored while in MD_BUSY.
- mdBusy = (state==MD_BUSY) or (state==IDLE and mdStartE).
- stallE = mdBusy.
- stallF = stallD = mdBusy or lwstall or brstall.
- flushE = (lwstall or brstall) and not mdBusy. While EX is held, no bubble is inserted.
- flushD = branchTakenD and not stallD. A taken branch that is simultaneously stalled is not flushed; it re-resolves next cycle.
- Latency: forwarding, stall and flush outputs are combinational from inputs and state, i.e. zero cycles.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - adds outputs stallCycles[31:0] and flushCount[31:0].
  - stallCycles increments on every cycle with stallD=1.
  - flushCount increments on every cycle with flushD or flushE=1.
  - both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: neither port nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the forward-select encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - the md FSM state enum.
  - the default MULT_CYCLES/DIV_CYCLES constants.
- Sub-module md_seq holds the IDLE/MD_BUSY FSM, counter and mdBusy/mdDone. The parent keeps forwarding and stall/flush logic.

Test Plan:
- Forwarding: RsE=5, regWriteM=1, writeRegM=5, regWriteW=1, writeRegW=5 -> forwardAE=10. Deassert regWriteM -> forwardAE=01. Set RsE=0 -> forwardAE=00.
- Load-use: memToRegE=1, RtE=8, RsD=8 -> stallF=stallD=flushE=1 for exactly 1 cycle; next cycle memToRegE=0 -> all 0, with no spurious forward.
- Branch hazard: branchD=1, RsD=9, memToRegM=1, writeRegM=9 -> stallD=1, flushE=1. Next cycle with regWriteM=1, writeRegM=9 -> forwardAD=1. Then branchTakenD=1 -> flushD=1 while stallD=0.
- Multiply: mdStartE=1, mdDivE=0 with MULT_CYCLES=4 -> stallE=1 for exactly 4 cycles (start cycle + 3 MD_BUSY cycles), mdDone high on the 4th only, flushE=0 throughout even if lwstall is true.
- Reset mid-divide: rst_n=0 on the 5th busy cycle -> next cycle mdBusy=0, all outputs 0, mdDone never pulses. After rst_n=1, a new mdStartE is accepted.
- HAZARD_PERF_CNT_EN defined: the load-use case plus a 4-cycle multiply -> stallCycles=5, flushCount=1.
